// File: rtl/cipher_pkg.sv
// cipher_pkg -- shared definitions for the cipher stream controller.
//   state_t   : controller FSM states
//   CHAR_*    : ASCII letter bounds used for alphabetic classification
//   is_alpha  : 1 when an 8-bit character is 'A'-'Z' or 'a'-'z'
package cipher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] CHAR_UC_A = 8'h41;
  localparam logic [7:0] CHAR_UC_Z = 8'h5A;
  localparam logic [7:0] CHAR_LC_A = 8'h61;
  localparam logic [7:0] CHAR_LC_Z = 8'h7A;

  function automatic logic is_alpha(input logic [7:0] c);
    return ((c >= CHAR_UC_A) && (c <= CHAR_UC_Z)) ||
           ((c >= CHAR_LC_A) && (c <= CHAR_LC_Z));
  endfunction

endpackage

// File: rtl/cipher_stream_ctrl.sv
// cipher_stream_ctrl -- one-character-in-flight controller in front of an
// external shift-cipher core with fixed result latency LAT (0..7).
//
// Parameters: CHAR_W (char width, >= 8), KEY_W (key width), LAT (core latency)
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   in_valid/in_ready/in_char    : input character handshake
//   key_in/mode_in/key_load      : key + mode (1=add, 0=sub), loaded in IDLE only
//   cph_a/cph_b/cph_addsub/cph_enable/cph_result : external cipher core
//   out_valid/out_ready/out_char : output character handshake
//   busy, key_err (sticky), char_count (characters delivered, wraps)
//
// Build option: CIPHER_PASSTHRU_EN -- non-alphabetic characters bypass the
// core and go straight from IDLE to HOLD.
module cipher_stream_ctrl
  import cipher_pkg::*;
#(
  parameter int CHAR_W = 8,
  parameter int KEY_W  = 4,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAR_W-1:0] in_char,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              mode_in,
  input  logic              key_load,
  output logic [CHAR_W-1:0] cph_a,
  output logic [KEY_W-1:0]  cph_b,
  output logic              cph_addsub,
  output logic              cph_enable,
  input  logic [CHAR_W-1:0] cph_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAR_W-1:0] out_char,
  output logic              busy,
  output logic              key_err,
  output logic [15:0]       char_count
);

  state_t              state_q, state_d;
  logic [2:0]          lat_cnt_q, lat_cnt_d;
  logic [CHAR_W-1:0]   char_q;
  logic [KEY_W-1:0]    key_q;
  logic                mode_q;
  logic [CHAR_W-1:0]   out_char_q;
  logic                key_err_q;
  logic [15:0]         char_count_q;

  logic accept, capture, deliver, pass;
  logic in_ready_c, out_valid_c, core_active;
  logic bypass;

`ifdef CIPHER_PASSTHRU_EN
  // Upper bits must be zero for a character to count as a letter.
  assign bypass = !(is_alpha(in_char[7:0]) && ((in_char >> 8) == '0));
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    accept      = 1'b0;
    capture     = 1'b0;
    deliver     = 1'b0;
    pass        = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    core_active = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (bypass) begin
            pass    = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        core_active = 1'b1;
        if (LAT == 0) begin
          capture = 1'b1;
          state_d = HOLD;
        end else begin
          // Counter holds remaining WAIT cycles minus one; capture at zero.
          lat_cnt_d = 3'(LAT - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        core_active = 1'b1;
        if (lat_cnt_q == 3'd0) begin
          capture = 1'b1;
          state_d = HOLD;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      HOLD: begin
        out_valid_c = 1'b1;
        if (out_ready) begin
          deliver = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      char_q       <= '0;
      key_q        <= '0;
      mode_q       <= 1'b1;
      out_char_q   <= '0;
      key_err_q    <= 1'b0;
      char_count_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      if (accept)  char_q     <= in_char;
      if (capture) out_char_q <= cph_result;
      if (pass)    out_char_q <= in_char;
      if (key_load) begin
        if (state_q == IDLE) begin
          key_q  <= key_in;
          mode_q <= mode_in;
        end else begin
          key_err_q <= 1'b1;
        end
      end
      if (deliver) char_count_q <= char_count_q + 16'd1;
    end
  end

  // Outputs are gated by reset so the reset values hold for the whole time
  // reset is high, not only from the first sampled edge.
  assign in_ready   = in_ready_c & ~reset;
  assign out_valid  = out_valid_c & ~reset;
  assign busy       = (state_q != IDLE) & ~reset;
  assign cph_enable = core_active & ~reset;
  assign cph_a      = cph_enable ? char_q : '0;
  assign cph_b      = cph_enable ? key_q : '0;
  assign cph_addsub = cph_enable ? mode_q : 1'b1;
  assign out_char   = reset ? '0 : out_char_q;
  assign key_err    = key_err_q & ~reset;
  assign char_count = reset ? '0 : char_count_q;

endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// tb_cipher_stream_ctrl -- directed self-checking bench for cipher_stream_ctrl.
// Main instance uses LAT=2; a second LAT=0 instance streams characters
// back-to-back to reach the char_count wrap.
module tb_cipher_stream_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [7:0] in_char;
  logic [3:0] key_in;
  logic       mode_in, key_load;
  logic [7:0] cph_a, cph_result;
  logic [3:0] cph_b;
  logic       cph_addsub, cph_enable;
  logic       out_valid, out_ready;
  logic [7:0] out_char;
  logic       busy, key_err;
  logic [15:0] char_count;

  logic       w_reset, w_in_valid, w_in_ready, w_key_load, w_mode_in;
  logic [7:0] w_in_char, w_cph_a, w_cph_result, w_out_char;
  logic [3:0] w_key_in, w_cph_b;
  logic       w_cph_addsub, w_cph_enable, w_out_valid, w_out_ready;
  logic       w_busy, w_key_err;
  logic [15:0] w_char_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Shift-cipher core model: add or subtract the zero-extended key.
  assign cph_result   = cph_addsub ? (cph_a + {4'b0, cph_b}) : (cph_a - {4'b0, cph_b});
  assign w_cph_result = w_cph_addsub ? (w_cph_a + {4'b0, w_cph_b}) : (w_cph_a - {4'b0, w_cph_b});

  cipher_stream_ctrl #(.CHAR_W(8), .KEY_W(4), .LAT(2)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .key_in(key_in), .mode_in(mode_in), .key_load(key_load),
    .cph_a(cph_a), .cph_b(cph_b), .cph_addsub(cph_addsub),
    .cph_enable(cph_enable), .cph_result(cph_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .busy(busy), .key_err(key_err), .char_count(char_count)
  );

  cipher_stream_ctrl #(.CHAR_W(8), .KEY_W(4), .LAT(0)) u_dut_wrap (
    .clk(clk), .reset(w_reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_char(w_in_char),
    .key_in(w_key_in), .mode_in(w_mode_in), .key_load(w_key_load),
    .cph_a(w_cph_a), .cph_b(w_cph_b), .cph_addsub(w_cph_addsub),
    .cph_enable(w_cph_enable), .cph_result(w_cph_result),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_char(w_out_char),
    .busy(w_busy), .key_err(w_key_err), .char_count(w_char_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_key(input logic [3:0] k, input logic m);
    @(negedge clk);
    key_load = 1'b1; key_in = k; mode_in = m;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  // Offers one character from IDLE and returns once out_valid is seen (or the
  // bound expires). n = edges after the accept edge, plus one. With kl set the
  // key strobe coincides with the accept (inj_n == 0) or is raised at the
  // negedge numbered inj_n.
  task automatic send(input logic [7:0] c, input bit kl, input logic [3:0] k,
                      input logic m, input int inj_n, output int n,
                      output int en_cnt, output logic [7:0] a_seen,
                      output logic [3:0] b_seen);
    n = 0; en_cnt = 0; a_seen = '0; b_seen = '0;
    @(negedge clk);
    in_valid = 1'b1; in_char = c;
    if (kl && inj_n == 0) begin
      key_load = 1'b1; key_in = k; mode_in = m;
    end
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        in_valid = 1'b0;
        if (inj_n == 0) key_load = 1'b0;
        a_seen = cph_a; b_seen = cph_b;
      end
      if (kl && inj_n > 0 && n == inj_n) begin
        key_load = 1'b1; key_in = k; mode_in = m;
      end else if (kl && inj_n > 0 && n == inj_n + 1) begin
        key_load = 1'b0;
      end
      if (cph_enable) en_cnt++;
    end while (!out_valid && n < 20);
    key_load = 1'b0;
  endtask

  task automatic deliver();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int n, en_cnt, d, cyc;
    logic [7:0] a_seen;
    logic [3:0] b_seen;
    bit stable;

    reset = 1'b1; in_valid = 1'b0; in_char = '0; key_in = '0; mode_in = 1'b0;
    key_load = 1'b0; out_ready = 1'b0;
    w_reset = 1'b1; w_in_valid = 1'b1; w_in_char = 8'h41; w_key_in = '0;
    w_mode_in = 1'b1; w_key_load = 1'b0; w_out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_char", out_char, 0);
    check("rst_cph_enable", cph_enable, 0);
    check("rst_cph_a", cph_a, 0);
    check("rst_cph_b", cph_b, 0);
    check("rst_cph_addsub", cph_addsub, 1);
    check("rst_busy", busy, 0);
    check("rst_key_err", key_err, 0);
    check("rst_char_count", char_count, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // key 3 encrypt, 'A' -> 'D' through a 2-cycle core
    load_key(4'd3, 1'b1);
    send(8'h41, 0, '0, 0, 0, n, en_cnt, a_seen, b_seen);
    check("A_issue_cph_a", a_seen, 8'h41);
    check("A_issue_cph_b", b_seen, 4'd3);
    check("A_valid_edges", n, 4);
    check("A_enable_cycles", en_cnt, 3);
    check("A_out_char", out_char, 8'h44);

    // backpressure in HOLD
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_char !== 8'h44 || in_ready !== 1'b0 ||
          cph_enable !== 1'b0) stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    deliver();
    check("deliver_busy", busy, 0);
    check("deliver_in_ready", in_ready, 1);
    check("deliver_out_valid", out_valid, 0);
    check("deliver_count", char_count, 1);

    // key load on the accept edge applies to that character (decrypt by 2)
    send(8'h50, 1, 4'd2, 1'b0, 0, n, en_cnt, a_seen, b_seen);
    check("coin_cph_b", b_seen, 4'd2);
    check("coin_out_char", out_char, 8'h4E);
    deliver();
    check("coin_count", char_count, 2);

    // key load during WAIT is ignored and flagged
    load_key(4'd3, 1'b1);
    send(8'h41, 1, 4'd5, 1'b0, 2, n, en_cnt, a_seen, b_seen);
    check("late_key_err", key_err, 1);
    check("late_out_char", out_char, 8'h44);
    deliver();
    send(8'h7A, 0, '0, 0, 0, n, en_cnt, a_seen, b_seen);
    check("late_key_kept", b_seen, 4'd3);
    check("late_z_out", out_char, 8'h7D);
    check("late_key_err_sticky", key_err, 1);
    deliver();
    check("late_count", char_count, 4);

    // reset while a character is in WAIT
    @(negedge clk);
    in_valid = 1'b1; in_char = 8'h42;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_in_wait", cph_enable, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid2", out_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_count", char_count, 0);
    check("post_rst_key_err", key_err, 0);
    send(8'h41, 0, '0, 0, 0, n, en_cnt, a_seen, b_seen);
    check("post_rst_key", b_seen, 4'd0);
    check("post_rst_out", out_char, 8'h41);
    deliver();

    // non-alphabetic character
    load_key(4'd1, 1'b1);
    send(8'h20, 0, '0, 0, 0, n, en_cnt, a_seen, b_seen);
`ifdef CIPHER_PASSTHRU_EN
    check("space_edges", n, 1);
    check("space_enable", en_cnt, 0);
    check("space_out", out_char, 8'h20);
`else
    check("space_edges", n, 4);
    check("space_enable", en_cnt, 3);
    check("space_out", out_char, 8'h21);
`endif
    deliver();
    check("space_count", char_count, 2);

    // char_count wrap on the streaming instance
    @(negedge clk);
    w_reset = 1'b0;
    d = 0; cyc = 0;
    while (d < 65535 && cyc < 250000) begin
      @(negedge clk);
      cyc++;
      if (w_out_valid) d++;
    end
    check("wrap_reached", d, 65535);
    @(negedge clk);
    check("wrap_ffff", w_char_count, 16'hFFFF);
    cyc = 0;
    while (!w_out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("wrap_last_valid", w_out_valid, 1);
    @(negedge clk);
    check("wrap_zero", w_char_count, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
